// File: rtl/mips32_pkg.sv
// Purpose: shared types and constants for the pipe_MIPS32 boot loader and its benches.
// Latency: none; this package holds declarations only.
// Backpressure: not applicable.
package mips32_pkg;

    localparam int WORD_W = 32;

    // HLT is the opcode-only instruction that makes the core raise HALTED.
    localparam logic [5:0]        HLT_OPCODE = 6'h3f;
    localparam logic [WORD_W-1:0] HLT_WORD   = {HLT_OPCODE, 26'd0};

    typedef enum logic [2:0] {
        ST_LOAD,
        ST_DRAIN,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } loader_state_t;

endpackage

// File: rtl/loader_wdog.sv
// Purpose: counts RUN cycles and flags expiry when the core has not halted in time.
// Latency: expire is combinational; it asserts during the CYCLES-th enabled cycle after clr.
// Backpressure: none; the counter saturates once expired.
//
// Ports:
//   clk1, rst_n  clock and asynchronous active-low reset
//   clr          zero the count (held while the loader is about to enter RUN)
//   en           count this cycle (loader is in RUN)
//   expire       this is the last allowed RUN cycle; the loader leaves RUN on the next edge
module loader_wdog #(
    parameter int CYCLES = 4096
) (
    input  logic clk1,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic expire
);

    localparam int CW = $clog2(CYCLES + 1);

    logic [CW-1:0] cnt;

    // cnt holds the number of RUN cycles already completed, so cnt==CYCLES-1
    // marks the CYCLES-th cycle; the edge that ends it is where the count
    // would reach CYCLES.
    assign expire = en && (cnt == CW'(CYCLES - 1));

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en && !expire) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mips32_prog_loader.sv
// Purpose: streams a program into pipe_MIPS32 memory from address 0, releases the core, waits for HALTED.
// Latency: a word accepted at edge k is on mem_* for one cycle from k+1; the core leaves reset 2 cycles after the last word.
// Backpressure: s_ready is high only while loading, so one word per cycle with no bubbles; it is low in every other state.
//
// Optional build macro: LOADER_WATCHDOG_EN adds a RUN-phase timeout of WDOG_CYCLES cycles
// that ends in the error state. Without it, RUN waits for HALTED indefinitely.
//
// Ports:
//   clk1, rst_n                    clock, asynchronous active-low reset
//   s_valid/s_ready/s_data/s_last  program word stream; s_last marks the final word
//   mem_we/mem_addr/mem_wdata      registered write port into core memory
//   core_rst_n                     core reset; high only in RUN and DONE
//   core_halted                    core HALTED flag; looked at only in RUN
//   word_count                     words accepted since reset
//   done, err                      sticky completion / overflow-or-timeout flags
import mips32_pkg::*;

module mips32_prog_loader #(
    parameter int ADDR_W      = 10,
    parameter int MAX_WORDS   = 1024,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    input  logic              s_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [WORD_W-1:0] mem_wdata,
    output logic              core_rst_n,
    input  logic              core_halted,
    output logic [ADDR_W:0]   word_count,
    output logic              done,
    output logic              err
);

    localparam int CNT_W = ADDR_W + 1;

    // Reject configurations whose capacity cannot be addressed.
    if (MAX_WORDS < 1 || MAX_WORDS > (1 << ADDR_W) || WDOG_CYCLES < 1) begin : g_bad_cfg
        $error("mips32_prog_loader: invalid MAX_WORDS/ADDR_W/WDOG_CYCLES combination");
    end

    loader_state_t state;
    loader_state_t state_nxt;

    logic hs;
    logic last_slot;
    logic wdog_expire;

    assign hs = s_valid && s_ready;

    // The word being accepted now fills the final slot.
    assign last_slot = (word_count == CNT_W'(MAX_WORDS - 1));

`ifdef LOADER_WATCHDOG_EN
    // The count is zeroed during DRAIN so it starts from 0 on the first RUN cycle.
    loader_wdog #(
        .CYCLES (WDOG_CYCLES)
    ) u_wdog (
        .clk1   (clk1),
        .rst_n  (rst_n),
        .clr    (state == ST_DRAIN),
        .en     (state == ST_RUN),
        .expire (wdog_expire)
    );
`else
    assign wdog_expire = 1'b0;
`endif

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_LOAD;
        end else begin
            state <= state_nxt;
        end
    end

    // Status outputs are decoded from state, so the asynchronous reset of the
    // state register alone returns them to reset values; in particular the
    // core is put back into reset immediately.
    always_comb begin
        state_nxt  = state;
        s_ready    = 1'b0;
        core_rst_n = 1'b0;
        done       = 1'b0;
        err        = 1'b0;
        case (state)
            ST_LOAD: begin
                s_ready = 1'b1;
                if (hs) begin
                    // s_last takes precedence: a program exactly filling
                    // memory is legal.
                    if (s_last) begin
                        state_nxt = ST_DRAIN;
                    end else if (last_slot) begin
                        state_nxt = ST_ERR;
                    end
                end
            end
            ST_DRAIN: begin
                // Final write is on the mem_* ports this cycle; the core
                // stays in reset until it has landed.
                state_nxt = ST_RUN;
            end
            ST_RUN: begin
                core_rst_n = 1'b1;
                // HALTED beats a timeout expiring on the same edge.
                if (core_halted) begin
                    state_nxt = ST_DONE;
                end else if (wdog_expire) begin
                    state_nxt = ST_ERR;
                end
            end
            ST_DONE: begin
                core_rst_n = 1'b1;
                done       = 1'b1;
            end
            ST_ERR: begin
                err = 1'b1;
            end
            default: begin
                state_nxt = ST_LOAD;
            end
        endcase
    end

    // Write port and word counter. mem_we is a single-cycle pulse per
    // accepted word; address and data hold their last values otherwise.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            word_count <= '0;
        end else begin
            mem_we <= hs;
            if (hs) begin
                mem_addr   <= word_count[ADDR_W-1:0];
                mem_wdata  <= s_data;
                word_count <= word_count + 1'b1;
            end
        end
    end

endmodule

// File: doc/mips32_prog_loader.md
# mips32_prog_loader

Boot-time program loader sitting directly upstream of the pipe_MIPS32 core. It accepts a stream of 32-bit instruction words over a valid/ready handshake and writes them into the core's instruction/data memory from address 0. It then releases the core from reset so it starts at PC=0, and reports completion when the core raises HALTED. This replaces hierarchical memory and register pokes with a real load-and-run sequence.

## Interface
- ADDR_W, 10: memory word-address width.
- MAX_WORDS, 1024: program capacity in words; must be ≤ 2**ADDR_W.
- WDOG_CYCLES, 4096: run-phase timeout; used only when the watchdog is compiled in.

Ports:
- clk1  in  1  single clock; all state updates on rising edge.
- rst_n  in  1  **asynchronous, active-low reset**.
- s_valid  in  1  program word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  32  instruction word.
- s_last  in  1  marks the final word of the program.
- mem_we  out  1  write strobe to core memory.
- mem_addr  out  ADDR_W  write word address.
- mem_wdata  out  32  write data.
- core_rst_n  out  1  core reset; low clears PC, HALTED and TAKEN_BRANCH.
- core_halted  in  1  core HALTED flag.
- word_count  out  ADDR_W+1  number of words accepted.
- done  out  1  program ran to HLT.
- err  out  1  overflow or watchdog timeout.

## Operation
- States: LOAD, DRAIN, RUN, DONE, ERR.
- Reset values: state=LOAD, s_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_rst_n=0, word_count=0, done=0, err=0.
- **LOAD**
  - s_ready=1.
  - A handshake occurs when s_valid && s_ready at an edge.
  - On a handshake: register mem_we=1, mem_addr=word_count[ADDR_W-1:0], mem_wdata=s_data; then increment word_count.
  - Otherwise mem_we=0.
- **LOAD exits**
  - Handshake with s_last=1: go to DRAIN.
  - Handshake that makes word_count==MAX_WORDS with s_last=0: the word is still written, then go to ERR (overflow).
- **DRAIN**
  - One cycle; s_ready=0.
  - The last write is visible on the mem_* ports this cycle.
  - Go to RUN.
- **RUN**
  - core_rst_n=1, s_ready=0, mem_we=0.
  - core_halted is sampled only in RUN; core_halted=1 goes to DONE.
- **DONE**
  - done=1, core_rst_n stays 1 so register contents remain observable.
  - Sticky until rst_n.
- **ERR**
  - err=1, core_rst_n=0, s_ready=0.
  - Sticky until rst_n.
- Boundary rules:
  - core_halted is ignored in LOAD and DRAIN.
  - s_valid is ignored outside LOAD; s_data may change freely while s_ready=0.
  - A zero-length program is impossible; the first word may carry s_last.
  - rst_n asserted mid-load or mid-run: all outputs return to reset values immediately (asynchronously); core_rst_n drops at once; memory contents are not cleared.

## Timing
- Handshake at edge k: mem_we/mem_addr/mem_wdata valid from k+1 for exactly one cycle.
- Back-to-back handshakes produce consecutive writes with one word per cycle and no bubbles.
- s_last handshake at edge k: DRAIN at k+1 with the last write on the ports; RUN, and core_rst_n=1, from k+2.
- core_halted=1 sampled at edge m in RUN: done=1 from m+1.
- word_count updates at the handshake edge.

## Configuration
- LOADER_WATCHDOG_EN
  - Defined: a run counter clears on entry to RUN and increments each RUN cycle.
  - If it reaches WDOG_CYCLES without core_halted, go to ERR (err=1 and core_rst_n=0 on the next edge).
  - If core_halted is sampled on the same edge the count reaches WDOG_CYCLES, DONE wins.
- Undefined: no counter exists, WDOG_CYCLES is unused, and RUN waits indefinitely.

## Structure
- Shared package mips32_pkg holds:
  - the loader state enum;
  - WORD_W=32;
  - HLT_OPCODE=6'h3f and the full HLT word 32'hfc000000 for benches.
- One sub-module, loader_wdog: the RUN-cycle counter with clear, enable and expire. It is instantiated only under LOADER_WATCHDOG_EN.

## Test plan
- **Nominal load:** stream the 9 words 2801000a, 28020014, 28030019, 0ce77800, 0ce77800, 20022200, 0ce77800, 00832800, fc000000 (last) with s_valid held high.
  - Expect writes to addr 0..8 on consecutive cycles and word_count=9.
  - Expect core_rst_n to rise 2 cycles after the last handshake.
  - Expect done=1 one cycle after core_halted is raised.
- **Gapped valid:** toggle s_valid every other cycle with 3 words.
  - Expect exactly 3 writes, at addrs 0,1,2, with no duplicates.
- **Overflow:** MAX_WORDS=4 and 4 words with no s_last.
  - Expect 4 writes, err=1 the cycle after the 4th handshake, and s_ready=0.
- **Early halt ignored:** hold core_halted=1 throughout LOAD.
  - Expect done=0 until RUN, then done=1 one cycle after RUN entry.
- **Mid-run reset:** assert rst_n=0 during RUN.
  - Expect core_rst_n=0 and word_count=0 immediately (asynchronously), and s_ready=1 after release.
- **Watchdog (LOADER_WATCHDOG_EN, WDOG_CYCLES=16):** core_halted never rises.
  - Expect err=1 and core_rst_n=0 exactly 16 RUN cycles after RUN entry.
